// File: rtl/i2s_rx_deserializer.sv
// i2s_rx_deserializer
// Oversamples a Philips-format I2S stream in the clk domain and turns each
// channel word into a DATA_WIDTH-bit two's-complement sample. A left word
// followed by a right word updates the stereo pair and the mono mix together
// with a one-cycle sample_valid. A word cut short by an early LRCLK change
// raises a one-cycle frame_err and is thrown away.
//
// Ports
//   clk           system clock (at least 4x BCLK)
//   rst_n         asynchronous active-low reset
//   i2s_bclk      external bit clock, asynchronous to clk
//   i2s_lrclk     word select (0 = left, 1 = right)
//   i2s_sdata     serial data, MSB first, valid on BCLK rising edge
//   left_out      last complete left sample
//   right_out     last complete right sample
//   audio_out     mono sample: left, right or floor average (MONO_MODE)
//   sample_valid  one-cycle pulse when the three outputs update
//   frame_err     one-cycle pulse when a word is truncated
module i2s_rx_deserializer #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int MONO_MODE   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i2s_bclk,
    input  logic                  i2s_lrclk,
    input  logic                  i2s_sdata,
    output logic [DATA_WIDTH-1:0] left_out,
    output logic [DATA_WIDTH-1:0] right_out,
    output logic [DATA_WIDTH-1:0] audio_out,
    output logic                  sample_valid,
    output logic                  frame_err
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_CAPTURE, ST_WAIT} state_t;

    // Synchronizer chains: bit 0 = bclk, bit 1 = lrclk, bit 2 = sdata.
    logic [2:0] ext_in;
    logic [2:0] ext_sync;
    assign ext_in = {i2s_sdata, i2s_lrclk, i2s_bclk};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) chain_reg <= '0;
                else        chain_reg <= {chain_reg[SYNC_STAGES-2:0], ext_in[gi]};
            end
            assign ext_sync[gi] = chain_reg[SYNC_STAGES-1];
        end
    endgenerate

    // lrclk and sdata are delayed alongside bclk so that, on a rise cycle,
    // lr_d_reg / sd_d_reg hold the values seen when the edge was detected.
    logic bclk_d_reg, lr_d_reg, sd_d_reg, rise_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_d_reg <= 1'b0;
            lr_d_reg   <= 1'b0;
            sd_d_reg   <= 1'b0;
            rise_reg   <= 1'b0;
        end else begin
            bclk_d_reg <= ext_sync[0];
            lr_d_reg   <= ext_sync[1];
            sd_d_reg   <= ext_sync[2];
            rise_reg   <= ext_sync[0] & ~bclk_d_reg;
        end
    end

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      bit_cnt_reg;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] left_stage_reg;
    logic                  left_valid_reg;
    logic                  lr_prev_reg;
    logic                  chan_reg;
    logic [DATA_WIDTH-1:0] left_out_reg, right_out_reg, audio_out_reg;
    logic                  sample_valid_reg, frame_err_reg;

    logic                  lr_change;
    logic                  shift_en, first_bit, commit, trunc, load_chan;
    logic [DATA_WIDTH-1:0] word;

    assign lr_change = lr_d_reg ^ lr_prev_reg;
    assign word      = {shift_reg[DATA_WIDTH-2:0], sd_d_reg};

    function automatic logic [DATA_WIDTH-1:0] mono_mix(
        input logic [DATA_WIDTH-1:0] l,
        input logic [DATA_WIDTH-1:0] r
    );
        logic signed [DATA_WIDTH:0] sum;
        sum = $signed({l[DATA_WIDTH-1], l}) + $signed({r[DATA_WIDTH-1], r});
        if (MONO_MODE == 0)      return l;
        else if (MONO_MODE == 1) return r;
        else                     return sum[DATA_WIDTH:1];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        shift_en   = 1'b0;
        first_bit  = 1'b0;
        commit     = 1'b0;
        trunc      = 1'b0;
        load_chan  = 1'b0;
        if (rise_reg) begin
            case (state_reg)
                ST_IDLE, ST_WAIT: begin
                    // This rise carries the previous word's LSB; skip it.
                    if (lr_change) begin
                        load_chan  = 1'b1;
                        state_next = ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    shift_en   = 1'b1;
                    first_bit  = 1'b1;
                    state_next = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (bit_cnt_reg == LAST_CNT) begin
                        // LSB rise. With slots of exactly DATA_WIDTH bits
                        // the channel flips on this same rise, so the next
                        // word starts straight away.
                        commit = 1'b1;
                        if (lr_change) begin
                            load_chan  = 1'b1;
                            state_next = ST_DELAY;
                        end else begin
                            state_next = ST_WAIT;
                        end
                    end else if (lr_change) begin
                        trunc      = 1'b1;
                        load_chan  = 1'b1;
                        state_next = ST_DELAY;
                    end else begin
                        shift_en = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_reg      <= '0;
            shift_reg        <= '0;
            left_stage_reg   <= '0;
            left_valid_reg   <= 1'b0;
            lr_prev_reg      <= 1'b0;
            chan_reg         <= 1'b0;
            left_out_reg     <= '0;
            right_out_reg    <= '0;
            audio_out_reg    <= '0;
            sample_valid_reg <= 1'b0;
            frame_err_reg    <= 1'b0;
        end else begin
            sample_valid_reg <= 1'b0;
            frame_err_reg    <= trunc;
            if (rise_reg) lr_prev_reg <= lr_d_reg;
            if (load_chan) chan_reg <= lr_d_reg;
            if (shift_en) begin
                shift_reg   <= word;
                bit_cnt_reg <= first_bit ? CNT_W'(1) : bit_cnt_reg + CNT_W'(1);
            end
            if (trunc) begin
                bit_cnt_reg    <= '0;
                left_valid_reg <= 1'b0;
            end
            if (commit) begin
                bit_cnt_reg <= '0;
                if (!chan_reg) begin
                    left_stage_reg <= word;
                    left_valid_reg <= 1'b1;
                end else if (left_valid_reg) begin
                    left_out_reg     <= left_stage_reg;
                    right_out_reg    <= word;
                    audio_out_reg    <= mono_mix(left_stage_reg, word);
                    sample_valid_reg <= 1'b1;
                    left_valid_reg   <= 1'b0;
                end
            end
        end
    end

    assign left_out     = left_out_reg;
    assign right_out    = right_out_reg;
    assign audio_out    = audio_out_reg;
    assign sample_valid = sample_valid_reg;
    assign frame_err    = frame_err_reg;

endmodule
